// File: rtl/blood_digit_render.sv
// rtl/blood_digit_render.sv - health-to-two-digit sprite renderer with 3-stage pixel pipeline
module blood_digit_render #(
    parameter logic [9:0]  X0     = 10'd32,
    parameter logic [9:0]  Y0     = 10'd16,
    parameter int          SPR    = 64,
    parameter logic [11:0] TRANSP = 12'h000,
    parameter logic [6:0]  HMAX   = 7'd99
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        video_on,
    input  logic [9:0]  x,
    input  logic [9:0]  y,
    input  logic        frame_tick,
    input  logic [6:0]  health,
    output logic [5:0]  rom_row,
    output logic [5:0]  rom_col,
    output logic [3:0]  digit_sel,
    input  logic [11:0] rom_color,
    output logic [11:0] rgb_out,
    output logic        rgb_on
);

    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

    // Region bounds widened by one bit so X0+2*SPR cannot wrap.
    localparam logic [10:0] XT0 = {1'b0, X0};
    localparam logic [10:0] XT1 = XT0 + 11'(SPR);
    localparam logic [10:0] XO1 = XT0 + 11'(2 * SPR);
    localparam logic [10:0] YT0 = {1'b0, Y0};
    localparam logic [10:0] YT1 = YT0 + 11'(SPR);

    state_t      state_q, state_d;
    logic [6:0]  v_q, v_d;
    logic [3:0]  tens_work_q, tens_work_d;
    logic [3:0]  disp_tens_q, disp_tens_d;
    logic [3:0]  disp_ones_q, disp_ones_d;

    logic [5:0]  row_q, row_d;
    logic [5:0]  col_q, col_d;
    logic        hit1_q, hit1_d;
    logic [3:0]  dig1_q, dig1_d;
    logic [3:0]  sel_q, sel_d;
    logic        hit2_q, hit2_d;
    logic [11:0] rgb_q, rgb_d;
    logic        on_q, on_d;

    logic        in_y, in_tens, in_ones, tens_blank;

    // Subtract-by-ten conversion; displayed digits only ever change together in DONE.
    always_comb begin
        state_d     = state_q;
        v_d         = v_q;
        tens_work_d = tens_work_q;
        disp_tens_d = disp_tens_q;
        disp_ones_d = disp_ones_q;
        case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    v_d         = (health > HMAX) ? HMAX : health;
                    tens_work_d = 4'd0;
                    state_d     = CONV;
                end
            end
            CONV: begin
                if (v_q >= 7'd10) begin
                    v_d         = v_q - 7'd10;
                    tens_work_d = tens_work_q + 4'd1;
                end else begin
                    state_d = DONE;
                end
            end
            DONE: begin
                disp_tens_d = tens_work_q;
                disp_ones_d = 4'(v_q);
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign tens_blank = (disp_tens_q == 4'd0);
    assign in_y       = ({1'b0, y} >= YT0) && ({1'b0, y} < YT1);
    assign in_tens    = in_y && ({1'b0, x} >= XT0) && ({1'b0, x} < XT1);
    assign in_ones    = in_y && ({1'b0, x} >= XT1) && ({1'b0, x} < XO1);

    // Pixel pipeline: address decode, digit select aligned with ROM, transparency merge.
    always_comb begin
        row_d  = 6'd0;
        col_d  = 6'd0;
        dig1_d = 4'd0;
        hit1_d = 1'b0;
        if (in_tens) begin
            row_d  = 6'(y - Y0);
            col_d  = 6'(x - X0);
            dig1_d = disp_tens_q;
            hit1_d = video_on && !tens_blank;
        end else if (in_ones) begin
            row_d  = 6'(y - Y0);
            col_d  = 6'(x - X0 - 10'(SPR));
            dig1_d = disp_ones_q;
            hit1_d = video_on;
        end
        sel_d  = dig1_q;
        hit2_d = hit1_q;
        if (hit2_q && (rom_color != TRANSP)) begin
            rgb_d = rom_color;
            on_d  = 1'b1;
        end else begin
            rgb_d = 12'h000;
            on_d  = 1'b0;
        end
    end

    // State and pipeline registers; reset discards any partial conversion.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            v_q         <= 7'd0;
            tens_work_q <= 4'd0;
            disp_tens_q <= 4'd0;
            disp_ones_q <= 4'd0;
            row_q       <= 6'd0;
            col_q       <= 6'd0;
            hit1_q      <= 1'b0;
            dig1_q      <= 4'd0;
            sel_q       <= 4'd0;
            hit2_q      <= 1'b0;
            rgb_q       <= 12'h000;
            on_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            v_q         <= v_d;
            tens_work_q <= tens_work_d;
            disp_tens_q <= disp_tens_d;
            disp_ones_q <= disp_ones_d;
            row_q       <= row_d;
            col_q       <= col_d;
            hit1_q      <= hit1_d;
            dig1_q      <= dig1_d;
            sel_q       <= sel_d;
            hit2_q      <= hit2_d;
            rgb_q       <= rgb_d;
            on_q        <= on_d;
        end
    end

    assign rom_row   = row_q;
    assign rom_col   = col_q;
    assign digit_sel = sel_q;
    assign rgb_out   = rgb_q;
    assign rgb_on    = on_q;

endmodule

// File: tb/tb_blood_digit_render.sv
// tb/tb_blood_digit_render.sv - scoreboard bench for blood_digit_render
`timescale 1ns/1ps
module tb_blood_digit_render;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        video_on = 1'b0;
    logic [9:0]  x = 10'd0;
    logic [9:0]  y = 10'd0;
    logic        frame_tick = 1'b0;
    logic [6:0]  health = 7'd0;
    logic [5:0]  rom_row;
    logic [5:0]  rom_col;
    logic [3:0]  digit_sel;
    logic [11:0] rom_color = 12'h000;
    logic [11:0] rgb_out;
    logic        rgb_on;

    int tests = 0;
    int fails = 0;

    logic        rom_transp = 1'b0;
    logic        pix_flag = 1'b0;
    logic        v1, v2, v3;
    logic [11:0] q_addr[$];
    logic [3:0]  q_sel[$];
    logic [12:0] q_rgb[$];
    logic [11:0] e_addr;
    logic [3:0]  e_sel;
    logic [12:0] e_rgb;

    blood_digit_render dut (
        .clk(clk), .reset(reset), .video_on(video_on), .x(x), .y(y),
        .frame_tick(frame_tick), .health(health), .rom_row(rom_row),
        .rom_col(rom_col), .digit_sel(digit_sel), .rom_color(rom_color),
        .rgb_out(rgb_out), .rgb_on(rgb_on)
    );

    always #5 clk = ~clk;

    // ROM model: registers the address, returns a solid red or a transparent pixel.
    always @(posedge clk) rom_color <= rom_transp ? 12'h000 : 12'hE00;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
        end else begin
            v1 <= pix_flag; v2 <= v1; v3 <= v2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: each pipeline stage pops its own expectation when a tagged pixel arrives.
    always @(negedge clk) begin
        if (!reset) begin
            if (v1) begin
                if (q_addr.size() == 0) chk("addr_underflow", 1, 0);
                else begin e_addr = q_addr.pop_front(); chk("rom_addr", {20'd0, rom_row, rom_col}, {20'd0, e_addr}); end
            end
            if (v2) begin
                if (q_sel.size() == 0) chk("sel_underflow", 1, 0);
                else begin e_sel = q_sel.pop_front(); chk("digit_sel", {28'd0, digit_sel}, {28'd0, e_sel}); end
            end
            if (v3) begin
                if (q_rgb.size() == 0) chk("rgb_underflow", 1, 0);
                else begin e_rgb = q_rgb.pop_front(); chk("rgb", {19'd0, rgb_on, rgb_out}, {19'd0, e_rgb}); end
            end
        end
    end

    task automatic pix(input logic [9:0] px, input logic [9:0] py, input logic vid,
                       input logic [5:0] er, input logic [5:0] ec, input logic [3:0] es,
                       input logic eon, input logic [11:0] ergb);
        @(negedge clk);
        x = px; y = py; video_on = vid; pix_flag = 1'b1;
        q_addr.push_back({er, ec});
        q_sel.push_back(es);
        q_rgb.push_back({eon, ergb});
    endtask

    task automatic flush();
        @(negedge clk);
        pix_flag = 1'b0; x = 10'd0; y = 10'd0; video_on = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic tick(input logic [6:0] h);
        @(negedge clk);
        health = h; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("reset_rgb_on", {31'd0, rgb_on}, 0);
        chk("reset_outs", {rom_row, rom_col, digit_sel, rgb_out}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Power-up display is a lone "0" in the ones slot.
        pix(10'd100, 10'd20, 1'b1, 6'd4, 6'd4, 4'd0, 1'b1, 12'hE00);
        pix(10'd40,  10'd20, 1'b1, 6'd4, 6'd8, 4'd0, 1'b0, 12'h000);
        flush();

        // health=7: conversion finishes in 3 cycles, tens blanked.
        tick(7'd7);
        repeat (2) @(negedge clk);
        pix(10'd101, 10'd21, 1'b1, 6'd5, 6'd5, 4'd7, 1'b1, 12'hE00);
        pix(10'd40,  10'd21, 1'b1, 6'd5, 6'd8, 4'd0, 1'b0, 12'h000);
        pix(10'd95,  10'd79, 1'b1, 6'd63, 6'd63, 4'd0, 1'b0, 12'h000);
        flush();

        // health=100 clamps to 99; corners and just-outside pixels.
        tick(7'd100);
        repeat (15) @(negedge clk);
        pix(10'd32,  10'd16, 1'b1, 6'd0,  6'd0,  4'd9, 1'b1, 12'hE00);
        pix(10'd95,  10'd79, 1'b1, 6'd63, 6'd63, 4'd9, 1'b1, 12'hE00);
        pix(10'd96,  10'd16, 1'b1, 6'd0,  6'd0,  4'd9, 1'b1, 12'hE00);
        pix(10'd159, 10'd79, 1'b1, 6'd63, 6'd63, 4'd9, 1'b1, 12'hE00);
        pix(10'd160, 10'd20, 1'b1, 6'd0,  6'd0,  4'd0, 1'b0, 12'h000);
        pix(10'd31,  10'd20, 1'b1, 6'd0,  6'd0,  4'd0, 1'b0, 12'h000);
        pix(10'd40,  10'd15, 1'b1, 6'd0,  6'd0,  4'd0, 1'b0, 12'h000);
        pix(10'd40,  10'd80, 1'b1, 6'd0,  6'd0,  4'd0, 1'b0, 12'h000);
        // Isolated hit: colour appears exactly three edges later and not before.
        pix(10'd35,  10'd18, 1'b1, 6'd2,  6'd3,  4'd9, 1'b1, 12'hE00);
        pix(10'd0,   10'd0,  1'b1, 6'd0,  6'd0,  4'd0, 1'b0, 12'h000);
        pix(10'd35,  10'd18, 1'b0, 6'd2,  6'd3,  4'd9, 1'b0, 12'h000);
        flush();

        rom_transp = 1'b1;
        pix(10'd35,  10'd18, 1'b1, 6'd2,  6'd3,  4'd9, 1'b0, 12'h000);
        pix(10'd100, 10'd18, 1'b1, 6'd2,  6'd4,  4'd9, 1'b0, 12'h000);
        flush();
        rom_transp = 1'b0;

        // A second frame_tick during CONV and a late health change are ignored.
        tick(7'd45);
        health = 7'd12; frame_tick = 1'b1;
        @(negedge clk);
        frame_tick = 1'b0;
        repeat (15) @(negedge clk);
        pix(10'd32,  10'd16, 1'b1, 6'd0,  6'd0,  4'd4, 1'b1, 12'hE00);
        pix(10'd103, 10'd25, 1'b1, 6'd9,  6'd7,  4'd5, 1'b1, 12'hE00);
        flush();
        tick(7'd12);
        repeat (15) @(negedge clk);
        pix(10'd33,  10'd17, 1'b1, 6'd1,  6'd1,  4'd1, 1'b1, 12'hE00);
        pix(10'd96,  10'd79, 1'b1, 6'd63, 6'd0,  4'd2, 1'b1, 12'hE00);
        flush();

        // Reset mid-conversion: outputs clear asynchronously, display returns to "0".
        x = 10'd101; y = 10'd21; video_on = 1'b1;
        repeat (4) @(negedge clk);
        chk("pre_reset_on", {31'd0, rgb_on}, 1);
        chk("pre_reset_sel", {28'd0, digit_sel}, 2);
        tick(7'd88);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rgb_on", {31'd0, rgb_on}, 0);
        chk("async_outs", {rom_row, rom_col, digit_sel, rgb_out}, 0);
        @(negedge clk);
        reset = 1'b0; x = 10'd0; y = 10'd0; video_on = 1'b0;
        repeat (20) @(negedge clk);
        pix(10'd101, 10'd21, 1'b1, 6'd5,  6'd5,  4'd0, 1'b1, 12'hE00);
        pix(10'd40,  10'd21, 1'b1, 6'd5,  6'd8,  4'd0, 1'b0, 12'h000);
        flush();

        chk("queues_drained", q_addr.size() + q_sel.size() + q_rgb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
